// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for one MAC block: takes a command, streams operand beats
// into the MAC, waits for the accumulator to settle and returns C over a valid/ready port.
module mac_seq_ctrl #(
  parameter int MIN_W   = 8,
  parameter int ACC_W   = 32,
  parameter int CONF_W  = 4,
  parameter int LEN_W   = 8,
  parameter int ACC_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    abort,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic [CONF_W-1:0]       cmd_mode,
  input  logic [ACC_W-1:0]        cmd_init,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [4*MIN_W-1:0]      op_a,
  input  logic [MIN_W-1:0]        op_b,
  output logic                    mac_en,
  output logic                    mac_acc_clr,
  output logic [MIN_W-1:0]        mac_a0,
  output logic [MIN_W-1:0]        mac_a1,
  output logic [MIN_W-1:0]        mac_a2,
  output logic [MIN_W-1:0]        mac_a3,
  output logic [MIN_W-1:0]        mac_b3,
  output logic [ACC_W+CONF_W-1:0] mac_cfg,
  input  logic [ACC_W-1:0]        mac_c,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_W-1:0]        res_data
);

  localparam int DRN_W = $clog2(ACC_LAT + 2);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [DRN_W-1:0] drain_cnt;
  logic             cmd_hs, op_hs, res_hs, last_beat, drain_end;

  assign cmd_ready = (state == S_IDLE);
  assign op_ready  = (state == S_STREAM);

  // abort outranks every handshake in the same cycle
  assign cmd_hs    = cmd_valid & cmd_ready & ~abort;
  assign op_hs     = op_valid & op_ready & ~abort;
  assign res_hs    = (state == S_DONE) & res_ready & ~abort;
  assign last_beat = op_hs && ((beat_cnt + LEN_W'(1)) == len_q);
  assign drain_end = (state == S_DRAIN) && (drain_cnt == DRN_W'(ACC_LAT));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cmd_hs) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = (len_q != '0) ? S_STREAM : S_DRAIN;
      S_STREAM: if (last_beat) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_end) state_nxt = S_DONE;
      S_DONE:   if (res_hs) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      len_q       <= '0;
      beat_cnt    <= '0;
      drain_cnt   <= '0;
      mac_en      <= 1'b0;
      mac_acc_clr <= 1'b0;
      mac_a0      <= '0;
      mac_a1      <= '0;
      mac_a2      <= '0;
      mac_a3      <= '0;
      mac_b3      <= '0;
      mac_cfg     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
    end else begin
      state       <= state_nxt;
      mac_en      <= op_hs;
      mac_acc_clr <= (state_nxt == S_CLEAR);
      res_valid   <= (state_nxt == S_DONE);

      if (cmd_hs) begin
        len_q   <= cmd_len;
        mac_cfg <= {cmd_init, cmd_mode};
      end

      // operand registers hold their last beat through DRAIN and beyond
      if (op_hs) begin
        {mac_a3, mac_a2, mac_a1, mac_a0} <= op_a;
        mac_b3                           <= op_b;
      end

      if (abort || cmd_hs) beat_cnt <= '0;
      else if (op_hs)      beat_cnt <= beat_cnt + LEN_W'(1);

      if (state != S_DRAIN) drain_cnt <= '0;
      else                  drain_cnt <= drain_cnt + DRN_W'(1);

      if (drain_end && !abort) res_data <= mac_c;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a behavioural MAC drives mac_c, a transaction-level model
// predicts every output each cycle, and directed scenarios pin hand-computed values.
module tb_mac_seq_ctrl;

  localparam int MIN_W   = 8;
  localparam int ACC_W   = 32;
  localparam int CONF_W  = 4;
  localparam int LEN_W   = 8;
  localparam int ACC_LAT = 1;
  localparam logic [CONF_W-1:0] MODE_ACC = 4'b1000;
  localparam logic [CONF_W-1:0] MODE_MUL = 4'b0000;

  logic                    clk = 1'b0;
  logic                    rst, abort, cmd_valid, op_valid, res_ready;
  logic                    cmd_ready, op_ready, mac_en, mac_acc_clr, res_valid;
  logic [LEN_W-1:0]        cmd_len;
  logic [CONF_W-1:0]       cmd_mode;
  logic [ACC_W-1:0]        cmd_init;
  logic [4*MIN_W-1:0]      op_a;
  logic [MIN_W-1:0]        op_b;
  logic [MIN_W-1:0]        mac_a0, mac_a1, mac_a2, mac_a3, mac_b3;
  logic [ACC_W+CONF_W-1:0] mac_cfg;
  logic [ACC_W-1:0]        mac_c, res_data;
  logic [ACC_W-1:0]        mac_acc = '0;

  mac_seq_ctrl #(.MIN_W(MIN_W), .ACC_W(ACC_W), .CONF_W(CONF_W), .LEN_W(LEN_W), .ACC_LAT(ACC_LAT)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_mode(cmd_mode), .cmd_init(cmd_init),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_en(mac_en), .mac_acc_clr(mac_acc_clr),
    .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2), .mac_a3(mac_a3), .mac_b3(mac_b3),
    .mac_cfg(mac_cfg), .mac_c(mac_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // MAC datapath stand-in: clear loads init (or 0 in mult-only), enable adds/overwrites A3*B3
  always @(posedge clk) begin
    if (mac_acc_clr)
      mac_acc <= mac_cfg[CONF_W-1] ? mac_cfg[ACC_W+CONF_W-1:CONF_W] : '0;
    else if (mac_en)
      mac_acc <= (mac_cfg[CONF_W-1] ? mac_acc : '0) + ACC_W'(mac_a3) * ACC_W'(mac_b3);
  end
  assign mac_c = mac_acc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Transaction-level expectation: phase plus remaining-beat and settle countdowns
  typedef enum int {P_IDLE, P_CLEAR, P_STREAM, P_DRAIN, P_DONE} ph_t;
  ph_t                     m_ph = P_IDLE;
  int                      m_beats_left = 0;
  int                      m_settle = 0;
  logic                    m_accsel = 1'b0;
  logic                    m_en = 1'b0, m_clr = 1'b0, m_rv = 1'b0;
  logic [ACC_W-1:0]        m_sum = '0, m_res = '0;
  logic [ACC_W+CONF_W-1:0] m_cfg = '0;
  logic [4*MIN_W-1:0]      m_a = '0;
  logic [MIN_W-1:0]        m_b = '0;
  bit                      started = 1'b0;

  task automatic model_step();
    logic [ACC_W-1:0] prod;
    if (!rst) begin
      m_ph = P_IDLE; m_en = 0; m_clr = 0; m_rv = 0;
      m_res = '0; m_cfg = '0; m_a = '0; m_b = '0; m_sum = '0;
      started = 1'b1;
    end else begin
      m_en = 0;
      m_clr = 0;
      if (abort) begin
        m_ph = P_IDLE;
        m_rv = 0;
      end else begin
        case (m_ph)
          P_IDLE: if (cmd_valid) begin
            m_beats_left = int'(cmd_len);
            m_cfg = {cmd_init, cmd_mode};
            m_accsel = cmd_mode[CONF_W-1];
            m_sum = m_accsel ? cmd_init : '0;
            m_clr = 1;
            m_ph = P_CLEAR;
          end
          P_CLEAR: begin
            if (m_beats_left == 0) begin m_ph = P_DRAIN; m_settle = ACC_LAT + 1; end
            else m_ph = P_STREAM;
          end
          P_STREAM: if (op_valid) begin
            m_en = 1;
            m_a = op_a;
            m_b = op_b;
            prod = ACC_W'(op_a[4*MIN_W-1 -: MIN_W]) * ACC_W'(op_b);
            m_sum = m_accsel ? m_sum + prod : prod;
            m_beats_left--;
            if (m_beats_left == 0) begin m_ph = P_DRAIN; m_settle = ACC_LAT + 1; end
          end
          P_DRAIN: begin
            m_settle--;
            if (m_settle == 0) begin m_ph = P_DONE; m_rv = 1; m_res = m_sum; end
          end
          P_DONE: if (res_ready) begin m_ph = P_IDLE; m_rv = 0; end
          default: m_ph = P_IDLE;
        endcase
      end
    end
  endtask

  int   en_cnt = 0, en_consec = 0, clr_cnt = 0, rise_cnt = 0, rise_cyc = 0;
  logic prev_en = 1'b0, prev_rv = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      if (started) begin
        chk("cmd_ready", 64'(cmd_ready), 64'(m_ph == P_IDLE));
        chk("op_ready", 64'(op_ready), 64'(m_ph == P_STREAM));
        chk("mac_en", 64'(mac_en), 64'(m_en));
        chk("mac_acc_clr", 64'(mac_acc_clr), 64'(m_clr));
        chk("res_valid", 64'(res_valid), 64'(m_rv));
        chk("res_data", 64'(res_data), 64'(m_res));
        chk("mac_cfg", 64'(mac_cfg), 64'(m_cfg));
        chk("mac_a", 64'({mac_a3, mac_a2, mac_a1, mac_a0}), 64'(m_a));
        chk("mac_b3", 64'(mac_b3), 64'(m_b));
        if (mac_en) en_cnt++;
        if (mac_en && prev_en) en_consec++;
        if (mac_acc_clr) clr_cnt++;
        if (res_valid && !prev_rv) begin rise_cnt++; rise_cyc = cyc; end
        prev_en = mac_en;
        prev_rv = res_valid;
      end
    end
  end

  int hs_cyc = 0, last_t = 0;

  task automatic clear_mon();
    en_cnt = 0; en_consec = 0; clr_cnt = 0; rise_cnt = 0;
  endtask

  task automatic send_cmd(input logic [LEN_W-1:0] len, input logic [CONF_W-1:0] mode,
                          input logic [ACC_W-1:0] init);
    int n = 0;
    cmd_valid = 1; cmd_len = len; cmd_mode = mode; cmd_init = init;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("cmd_accept_wait", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    hs_cyc = cyc - 1;
    cmd_valid = 0;
  endtask

  task automatic beat(input logic [MIN_W-1:0] a3, input logic [MIN_W-1:0] b3, input int gap);
    int n = 0;
    op_valid = 1;
    op_a = {a3, a3 ^ 8'h5A, 8'hA5, a3 + 8'h10};
    op_b = b3;
    while (!op_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("op_accept_wait", 64'(op_ready), 64'(1));
    @(posedge clk); #1;
    last_t = cyc - 1;
    op_valid = 0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("res_valid_wait", 64'(res_valid), 64'(1));
  endtask

  task automatic get_result(output logic [ACC_W-1:0] d);
    wait_valid();
    d = res_data;
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ACC_W-1:0] d;
    rst = 0; abort = 0; cmd_valid = 0; op_valid = 0; res_ready = 0;
    cmd_len = '0; cmd_mode = '0; cmd_init = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1;
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("reset_op_ready", 64'(op_ready), 64'(0));
    chk("reset_mac_en", 64'(mac_en), 64'(0));
    chk("reset_res_valid", 64'(res_valid), 64'(0));
    chk("reset_mac_cfg", 64'(mac_cfg), 64'(0));

    // 1: 5 + 2*3 + 4*5 + 1*1 = 32, back-to-back beats
    clear_mon();
    send_cmd(8'd3, MODE_ACC, 32'd5);
    beat(8'd2, 8'd3, 0); beat(8'd4, 8'd5, 0); beat(8'd1, 8'd1, 0);
    get_result(d);
    chk("t1_res_data", 64'(d), 64'(32));
    chk("t1_latency", 64'(rise_cyc - last_t), 64'(3));
    chk("t1_en_pulses", 64'(en_cnt), 64'(3));
    chk("t1_en_consecutive", 64'(en_consec), 64'(2));
    chk("t1_clr_pulses", 64'(clr_cnt), 64'(1));

    // 2: same vector with a bubble after every beat
    clear_mon();
    send_cmd(8'd3, MODE_ACC, 32'd5);
    beat(8'd2, 8'd3, 1); beat(8'd4, 8'd5, 1); beat(8'd1, 8'd1, 1);
    get_result(d);
    chk("t2_res_data", 64'(d), 64'(32));
    chk("t2_en_pulses", 64'(en_cnt), 64'(3));
    chk("t2_en_consecutive", 64'(en_consec), 64'(0));

    // 3: empty vector returns the initial value
    clear_mon();
    send_cmd(8'd0, MODE_ACC, 32'h1234);
    get_result(d);
    chk("t3_res_data", 64'(d), 64'h1234);
    chk("t3_latency", 64'(rise_cyc - hs_cyc), 64'(4));
    chk("t3_en_pulses", 64'(en_cnt), 64'(0));
    chk("t3_clr_pulses", 64'(clr_cnt), 64'(1));

    // 4: result back-pressure with a pending command
    send_cmd(8'd1, MODE_ACC, 32'd10);
    beat(8'd2, 8'd3, 0);
    wait_valid();
    cmd_valid = 1; cmd_len = 8'd0; cmd_mode = MODE_ACC; cmd_init = 32'h55;
    repeat (5) begin
      chk("t4_hold_res_data", 64'(res_data), 64'(16));
      chk("t4_hold_cmd_ready", 64'(cmd_ready), 64'(0));
      @(posedge clk); #1;
    end
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    chk("t4_idle_cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 0;
    chk("t4_clear_pulse", 64'(mac_acc_clr), 64'(1));
    chk("t4_new_cfg", 64'(mac_cfg), 64'({32'h55, MODE_ACC}));
    get_result(d);
    chk("t4_res_data", 64'(d), 64'h55);

    // 5: abort after two of four beats, then a fresh command: 7 + 3*3 = 16
    clear_mon();
    send_cmd(8'd4, MODE_ACC, 32'd0);
    beat(8'd1, 8'd1, 0); beat(8'd2, 8'd2, 0);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("t5_op_ready", 64'(op_ready), 64'(0));
    chk("t5_cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (4) begin @(posedge clk); #1; end
    chk("t5_no_result", 64'(rise_cnt), 64'(0));
    send_cmd(8'd1, MODE_ACC, 32'd7);
    beat(8'd3, 8'd3, 0);
    get_result(d);
    chk("t5_res_data", 64'(d), 64'(16));

    // mult-only: result is the last product, 5*6 = 30
    send_cmd(8'd2, MODE_MUL, 32'h99);
    beat(8'd3, 8'd4, 0); beat(8'd5, 8'd6, 0);
    get_result(d);
    chk("mul_res_data", 64'(d), 64'(30));

    // 6: reset while draining
    clear_mon();
    send_cmd(8'd1, MODE_ACC, 32'd3);
    beat(8'd2, 8'd2, 0);
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    chk("t6_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("t6_op_ready", 64'(op_ready), 64'(0));
    chk("t6_mac_en", 64'(mac_en), 64'(0));
    chk("t6_res_valid", 64'(res_valid), 64'(0));
    chk("t6_res_data", 64'(res_data), 64'(0));
    chk("t6_mac_cfg", 64'(mac_cfg), 64'(0));
    chk("t6_mac_a3", 64'(mac_a3), 64'(0));
    repeat (5) begin @(posedge clk); #1; end
    chk("t6_no_result", 64'(rise_cnt), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
